// File: rtl/serializer_defs_pkg.sv
// Shared definitions for the LSB-first serializer: FSM state encodings and
// the frame-length helper. Honours the SERIALIZER_PARITY_EN build macro.
package serializer_defs;

    // 2-bit state encodings, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Number of serial bits per frame: data bits plus the optional parity slot.
    function automatic int unsigned FRAME_LEN(input int unsigned width);
        return PARITY_EN ? (width + 1) : width;
    endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Frame bit counter for the LSB-first serializer.
// Synchronous clear has priority over increment; tc_o flags count == TERM.
module serializer_bit_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TERM  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise step by one when asked.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Output view of the count and its terminal value.
    always_comb begin
        count_o = count_q;
        tc_o    = (count_q == CNT_W'(TERM));
    end

endmodule

// File: rtl/lsb_first_serializer.sv
// LSB-first serializer: takes one parallel word per valid/ready handshake and
// shifts it out one bit per clock, bit 0 first, with first/last frame markers.
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit to
// every frame (frame becomes WIDTH+1 bits, ser_last moves to the parity bit).
module lsb_first_serializer
    import serializer_defs::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    // Counter value carried by the final frame bit (data MSB or parity slot).
    localparam int unsigned LAST_IDX = FRAME_LEN(WIDTH) - 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [CNT_W-1:0] count;
    logic             count_tc;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             last_data;
    logic             accept;

    serializer_bit_counter #(
        .CNT_W (CNT_W),
        .TERM  (WIDTH - 1)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (count),
        .tc_o    (count_tc)
    );

    // Output flags decoded from state and bit position.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        ser_valid = busy;
        ser_first = (state_q == ST_SHIFT) && (count == '0);
        ser_last  = busy && (count == CNT_W'(LAST_IDX));
        // Ready while idle and on the last frame bit, so frames can abut.
        in_ready  = (state_q == ST_IDLE) || ser_last;
        ser_out   = 1'b0;
        if (state_q == ST_SHIFT) begin
            ser_out = shift_q[0];
        end
`ifdef SERIALIZER_PARITY_EN
        if (state_q == ST_PARITY) begin
            ser_out = parity_q;
        end
`endif
    end

    // Handshake and last-data-bit detection.
    always_comb begin
        accept    = in_valid && in_ready;
        last_data = (state_q == ST_SHIFT) && count_tc;
    end

    // FSM, shift register and counter control.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
            end
            ST_SHIFT: begin
                if (!last_data) begin
                    shift_d = shift_q >> 1;
                    cnt_inc = 1'b1;
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    state_d = ST_PARITY;
                    shift_d = '0;
                    cnt_inc = 1'b1;
`else
                    state_d = ST_IDLE;
                    shift_d = '0;
                    cnt_clr = 1'b1;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                state_d  = ST_IDLE;
                shift_d  = '0;
                parity_d = 1'b0;
                cnt_clr  = 1'b1;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_clr = 1'b1;
            end
        endcase

        // A new word (only possible when idle or on the last frame bit)
        // overrides the end-of-frame transition and restarts at bit 0.
        if (accept) begin
            state_d = ST_SHIFT;
            shift_d = in_data;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_d = ^in_data;
`endif
        end
    end

    // State registers; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsb_first_serializer.sv
// Self-checking bench for lsb_first_serializer (WIDTH=8 and WIDTH=4 instances).
// The reference model expands each accepted word into a queue of frame bits.
module tb_lsb_first_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN8 = 8 + int'(PAR);
    localparam int FLEN4 = 4 + int'(PAR);

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } fbit_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data8;
    logic       in_valid8;
    logic [3:0] in_data4;
    logic       in_valid4;
    logic       in_ready8, ser_out8, ser_valid8, ser_first8, ser_last8, busy8;
    logic       in_ready4, ser_out4, ser_valid4, ser_first4, ser_last4, busy4;
    logic [5:0] obs8, obs4;

    int n_vec = 0;
    int n_bad = 0;

    fbit_t q8[$];
    fbit_t q4[$];

    lsb_first_serializer #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .ser_out   (ser_out8),
        .ser_valid (ser_valid8),
        .ser_first (ser_first8),
        .ser_last  (ser_last8),
        .busy      (busy8)
    );

    lsb_first_serializer #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .ser_out   (ser_out4),
        .ser_valid (ser_valid4),
        .ser_first (ser_first4),
        .ser_last  (ser_last4),
        .busy      (busy4)
    );

    // {valid, out, first, last, busy, ready}
    assign obs8 = {ser_valid8, ser_out8, ser_first8, ser_last8, busy8, in_ready8};
    assign obs4 = {ser_valid4, ser_out4, ser_first4, ser_last4, busy4, in_ready4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_frame8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            q8.push_back('{b: w[i], first: (i == 0), last: (!PAR && i == 7)});
        end
        if (PAR) q8.push_back('{b: ^w, first: 1'b0, last: 1'b1});
    endfunction

    function automatic void push_frame4(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            q4.push_back('{b: w[i], first: (i == 0), last: (!PAR && i == 3)});
        end
        if (PAR) q4.push_back('{b: ^w, first: 1'b0, last: 1'b1});
    endfunction

    // Expected outputs: idle when nothing queued, else the head frame bit.
    // in_ready is high when idle or when the head is the frame's last bit.
    function automatic logic [5:0] exp8();
        if (q8.size() == 0) return 6'b000001;
        return {1'b1, q8[0].b, q8[0].first, q8[0].last, 1'b1, q8[0].last};
    endfunction

    function automatic logic [5:0] exp4();
        if (q4.size() == 0) return 6'b000001;
        return {1'b1, q4[0].b, q4[0].first, q4[0].last, 1'b1, q4[0].last};
    endfunction

    // One clock: sample at negedge, drive inputs, advance model at posedge.
    task automatic cycle(input logic v8, input logic [7:0] d8,
                         input logic v4, input logic [3:0] d4,
                         output logic [5:0] s8, output logic [5:0] e8,
                         output logic [5:0] s4, output logic [5:0] e4);
        logic a8, a4;
        @(negedge clk);
        s8 = obs8;
        e8 = exp8();
        s4 = obs4;
        e4 = exp4();
        in_valid8 = v8;
        in_data8  = d8;
        in_valid4 = v4;
        in_data4  = d4;
        a8 = v8 && e8[0];
        a4 = v4 && e4[0];
        @(posedge clk);
        if (q8.size() > 0) void'(q8.pop_front());
        if (q4.size() > 0) void'(q4.pop_front());
        if (a8) push_frame8(d8);
        if (a4) push_frame4(d4);
    endtask

    task automatic test_reset();
        logic [5:0] s8, e8, s4, e4;
        rst_n = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; in_valid4 = 1'b0; in_data4 = '0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
            n_vec++;
            if (s8 !== 6'b000001) begin
                n_bad++;
                $display("FAIL reset_w8: got %b expected %b", s8, 6'b000001);
            end
            n_vec++;
            if (s4 !== 6'b000001) begin
                n_bad++;
                $display("FAIL reset_w4: got %b expected %b", s4, 6'b000001);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
        n_vec++;
        if (s8 !== e8) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b expected %b", s8, e8);
        end
    endtask

    task automatic test_directed(input logic [7:0] w);
        logic [5:0] s8, e8, s4, e4;
        logic [8:0] got;
        logic [8:0] want;
        got  = '0;
        want = {PAR & (^w), w};
        cycle(1'b1, w, 1'b0, 4'h0, s8, e8, s4, e4);
        n_vec++;
        if (s8 !== e8) begin
            n_bad++;
            $display("FAIL directed_accept %h: got %b expected %b", w, s8, e8);
        end
        for (int i = 0; i < FLEN8; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
            got[i] = s8[4];
            n_vec++;
            if (s8 !== e8) begin
                n_bad++;
                $display("FAIL directed_bit %h[%0d]: got %b expected %b", w, i, s8, e8);
            end
            n_vec++;
            if (s8[3] !== (i == 0) || s8[2] !== (i == FLEN8 - 1)) begin
                n_bad++;
                $display("FAIL directed_markers %h[%0d]: got first=%b last=%b", w, i, s8[3], s8[2]);
            end
        end
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL directed_stream %h: got %b expected %b", w, got, want);
        end
        cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
        n_vec++;
        if (s8 !== 6'b000001) begin
            n_bad++;
            $display("FAIL directed_idle %h: got %b expected %b", w, s8, 6'b000001);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] s8, e8, s4, e4;
        int k, nvalid, nready_busy, first_v, last_v;
        int firsts[$];
        k = 0; nvalid = 0; nready_busy = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 2 * FLEN8 + 4; c++) begin
            logic v;
            logic [7:0] d;
            v = (k < 2);
            d = (k == 0) ? 8'hA5 : 8'h3C;
            cycle(v, d, 1'b0, 4'h0, s8, e8, s4, e4);
            n_vec++;
            if (s8 !== e8) begin
                n_bad++;
                $display("FAIL b2b_cycle %0d: got %b expected %b", c, s8, e8);
            end
            if (s8[5]) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                last_v = c;
                if (s8[0]) nready_busy++;
            end
            if (s8[3]) firsts.push_back(c);
            if (v && e8[0]) k++;
        end
        n_vec++;
        if (nvalid != 2 * FLEN8 || (last_v - first_v + 1) != nvalid) begin
            n_bad++;
            $display("FAIL b2b_valid_run: got %0d cycles span %0d expected %0d", nvalid,
                     last_v - first_v + 1, 2 * FLEN8);
        end
        n_vec++;
        if (firsts.size() != 2 || (firsts.size() == 2 && firsts[1] - firsts[0] != FLEN8)) begin
            n_bad++;
            $display("FAIL b2b_first_spacing: got %0d markers expected 2 spaced %0d",
                     firsts.size(), FLEN8);
        end
        n_vec++;
        if (nready_busy != 2) begin
            n_bad++;
            $display("FAIL b2b_ready_in_frame: got %0d expected 2", nready_busy);
        end
    endtask

    task automatic test_ignore();
        logic [5:0] s8, e8, s4, e4;
        logic [7:0] w;
        logic [8:0] got;
        w = 8'($urandom);
        got = '0;
        cycle(1'b1, w, 1'b0, 4'h0, s8, e8, s4, e4);
        for (int i = 0; i < FLEN8; i++) begin
            logic v;
            v = (i == 2);
            cycle(v, v ? 8'hFF : 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
            got[i] = s8[4];
            n_vec++;
            if (s8 !== e8) begin
                n_bad++;
                $display("FAIL ignore_bit[%0d]: got %b expected %b", i, s8, e8);
            end
            if (i == 2) begin
                n_vec++;
                if (s8[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ignore_ready: got %b expected 0", s8[0]);
                end
            end
        end
        n_vec++;
        if (got !== {PAR & (^w), w}) begin
            n_bad++;
            $display("FAIL ignore_stream: got %b expected %b", got, {PAR & (^w), w});
        end
        cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
        n_vec++;
        if (s8 !== 6'b000001) begin
            n_bad++;
            $display("FAIL ignore_no_queue: got %b expected %b", s8, 6'b000001);
        end
    endtask

    task automatic test_reset_midframe();
        logic [5:0] s8, e8, s4, e4;
        cycle(1'b1, 8'hB1, 1'b1, 4'h9, s8, e8, s4, e4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
        end
        @(negedge clk);
        n_vec++;
        if (obs8 !== exp8()) begin
            n_bad++;
            $display("FAIL midrst_bit4: got %b expected %b", obs8, exp8());
        end
        #2;
        rst_n = 1'b0;
        #1;
        q8.delete();
        q4.delete();
        n_vec++;
        if (obs8 !== 6'b000001) begin
            n_bad++;
            $display("FAIL midrst_async_w8: got %b expected %b", obs8, 6'b000001);
        end
        n_vec++;
        if (obs4 !== 6'b000001) begin
            n_bad++;
            $display("FAIL midrst_async_w4: got %b expected %b", obs4, 6'b000001);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FLEN8 + 2; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
            n_vec++;
            if (s8 !== 6'b000001 || s4 !== 6'b000001) begin
                n_bad++;
                $display("FAIL midrst_residual[%0d]: got w8=%b w4=%b expected idle", i, s8, s4);
            end
        end
    endtask

    task automatic test_width4();
        logic [5:0] s8, e8, s4, e4;
        logic [4:0] got;
        got = '0;
        cycle(1'b0, 8'h00, 1'b1, 4'b1100, s8, e8, s4, e4);
        for (int i = 0; i < FLEN4; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
            got[i] = s4[4];
            n_vec++;
            if (s4 !== e4) begin
                n_bad++;
                $display("FAIL w4_bit[%0d]: got %b expected %b", i, s4, e4);
            end
        end
        n_vec++;
        if (got !== {1'b0, 4'b1100}) begin
            n_bad++;
            $display("FAIL w4_stream: got %b expected %b", got, {1'b0, 4'b1100});
        end
        cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
        n_vec++;
        if (s4[1] !== 1'b0 || s4[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL w4_idle: got busy=%b ready=%b expected busy=0 ready=1", s4[1], s4[0]);
        end
    endtask

    task automatic test_random();
        logic [5:0] s8, e8, s4, e4;
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) != 0, 4'($urandom), s8, e8, s4, e4);
            n_vec++;
            if (s8 !== e8) begin
                n_bad++;
                $display("FAIL random_w8 cycle %0d: got %b expected %b", c, s8, e8);
            end
            n_vec++;
            if (s4 !== e4) begin
                n_bad++;
                $display("FAIL random_w4 cycle %0d: got %b expected %b", c, s4, e4);
            end
        end
        for (int c = 0; c < FLEN8 + 2; c++) begin
            cycle(1'b0, 8'h00, 1'b0, 4'h0, s8, e8, s4, e4);
        end
    endtask

    initial begin
        test_reset();
        test_directed(8'b1011_0001);
        test_directed(8'h07);
        test_directed(8'($urandom));
        test_back_to_back();
        test_ignore();
        test_reset_midframe();
        test_width4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
